memory_port_arbiter: RTL and testbench

- Sequences and shares RAM port B (addr_b/din_b/we_b/dout_b) between two requesters:
  - req0: data-cache line refill/writeback.
  - req1: uncached load/store path, covering MMIO at addr[17:16]==2'b11.
- Round-robin arbitration issues one transaction at a time, applies the 1-cycle RAM read latency, and returns captured read data with a done pulse.
- Sits between the load/store side of CentralProcessingUnit and port B; port A (instruction side) is untouched.

---
 rtl/memory_port_arbiter_pkg.sv | 16 +
 rtl/memory_port_arbiter_rr_arbiter_2.sv | 16 +
 rtl/memory_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_memory_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_port_arbiter_pkg.sv
// Shared constants for the port-B memory arbiter: state encoding, MMIO prefix, requester ids.
package memory_port_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t ISSUE   = 2'd1;
    localparam state_t CAPTURE = 2'd2;

    // MMIO window lives at addr[17:16]; it is passed through with no special handling
    localparam logic [1:0] IO_PREFIX = 2'b11;

    localparam logic REQ_DCACHE   = 1'b0;
    localparam logic REQ_UNCACHED = 1'b1;

endpackage

// File: rtl/memory_port_arbiter_rr_arbiter_2.sv
// Two-way round-robin winner select; purely combinational.
module rr_arbiter_2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_winner,
    output logic winner_id,
    output logic any_valid
);

    // On a tie the requester that did not win last time gets the port
    always_comb begin
        any_valid = valid0 | valid1;
        winner_id = (valid0 && valid1) ? ~last_winner : valid1;
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares RAM port B between the data cache (req0) and the uncached load/store path (req1).
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned RAM_WIDTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [RAM_WIDTH-1:0]  req0_wdata,
    output logic                  req0_grant,
    output logic                  req0_done,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [RAM_WIDTH-1:0]  req1_wdata,
    output logic                  req1_grant,
    output logic                  req1_done,
    output logic [RAM_WIDTH-1:0]  rdata,
    input  logic [RAM_WIDTH-1:0]  dout_b,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [RAM_WIDTH-1:0]  din_b,
    output logic                  we_b
);

    state_t                state;
    state_t                state_nxt;
    logic                  we_r;
    logic                  we_nxt;
    logic                  last_winner;
    logic                  last_nxt;
    logic                  winner_id_r;
    logic                  winner_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [RAM_WIDTH-1:0]  din_nxt;
    logic [RAM_WIDTH-1:0]  rdata_nxt;
    logic                  grant0_nxt;
    logic                  grant1_nxt;
    logic                  done0_nxt;
    logic                  done1_nxt;
    logic                  arb_winner;
    logic                  arb_any;

    rr_arbiter_2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_winner (last_winner),
        .winner_id   (arb_winner),
        .any_valid   (arb_any)
    );

    // A stalled write must not reach the RAM; it re-asserts once rdy returns
    assign we_b = we_r & rdy;

    // State register; rdy low freezes the sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    // Next-state: writes finish after ISSUE, reads take one extra cycle to capture dout_b
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = arb_any ? ISSUE : IDLE;
            ISSUE:   state_nxt = we_r ? IDLE : CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output next values: latch the winner's transaction, pulse grant/done for one cycle
    always_comb begin
        addr_nxt   = addr_b;
        din_nxt    = din_b;
        we_nxt     = we_r;
        last_nxt   = last_winner;
        winner_nxt = winner_id_r;
        rdata_nxt  = rdata;
        grant0_nxt = 1'b0;
        grant1_nxt = 1'b0;
        done0_nxt  = 1'b0;
        done1_nxt  = 1'b0;
        case (state)
            IDLE: begin
                we_nxt = 1'b0;
                if (arb_any) begin
                    addr_nxt   = (arb_winner == REQ_DCACHE) ? req0_addr  : req1_addr;
                    din_nxt    = (arb_winner == REQ_DCACHE) ? req0_wdata : req1_wdata;
                    we_nxt     = (arb_winner == REQ_DCACHE) ? req0_we    : req1_we;
                    last_nxt   = arb_winner;
                    winner_nxt = arb_winner;
                    grant0_nxt = (arb_winner == REQ_DCACHE);
                    grant1_nxt = (arb_winner == REQ_UNCACHED);
                end
            end
            ISSUE: begin
                if (we_r) begin
                    we_nxt    = 1'b0;
                    done0_nxt = (winner_id_r == REQ_DCACHE);
                    done1_nxt = (winner_id_r == REQ_UNCACHED);
                end
            end
            CAPTURE: begin
                rdata_nxt = dout_b;
                done0_nxt = (winner_id_r == REQ_DCACHE);
                done1_nxt = (winner_id_r == REQ_UNCACHED);
            end
            default: begin
                we_nxt = 1'b0;
            end
        endcase
    end

    // Output registers; pulses are held, not consumed, while rdy is low
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_b      <= '0;
            din_b       <= '0;
            we_r        <= 1'b0;
            last_winner <= REQ_UNCACHED;
            winner_id_r <= REQ_DCACHE;
            rdata       <= '0;
            req0_grant  <= 1'b0;
            req1_grant  <= 1'b0;
            req0_done   <= 1'b0;
            req1_done   <= 1'b0;
        end else if (rdy) begin
            addr_b      <= addr_nxt;
            din_b       <= din_nxt;
            we_r        <= we_nxt;
            last_winner <= last_nxt;
            winner_id_r <= winner_nxt;
            rdata       <= rdata_nxt;
            req0_grant  <= grant0_nxt;
            req1_grant  <= grant1_nxt;
            req0_done   <= done0_nxt;
            req1_done   <= done1_nxt;
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: vector table, corner sequences, random vs. model.
module tb_memory_port_arbiter;

    // 18-bit address so the MMIO prefix at addr[17:16] is representable
    localparam int unsigned AW    = 18;
    localparam int unsigned DW    = 128;
    localparam int unsigned NRAND = 600;
    localparam logic [DW-1:0] DEAD = 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic          req0_valid, req0_we, req1_valid, req1_we;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          req0_grant, req0_done, req1_grant, req1_done;
    logic [DW-1:0] rdata, dout_b, din_b;
    logic [AW-1:0] addr_b;
    logic          we_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    memory_port_arbiter #(.ADDR_WIDTH(AW), .RAM_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_grant(req0_grant), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_grant(req1_grant), .req1_done(req1_done),
        .rdata(rdata), .dout_b(dout_b), .addr_b(addr_b), .din_b(din_b), .we_b(we_b)
    );

    // Behavioural RAM with one-cycle read latency, indexed by addr[9:0]
    logic [DW-1:0] ram [0:1023];
    bit            ram_ready = 1'b0;

    function automatic logic [DW-1:0] ram_pat(input int i);
        if (i == 32'h100) return DEAD;
        return {4{i ^ 32'hA5A5_0000}};
    endfunction

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) ram[i] <= ram_pat(i);
            ram_ready <= 1'b1;
        end else if (we_b) begin
            ram[addr_b[9:0]] <= din_b;
        end
        dout_b <= ram[addr_b[9:0]];
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %b want %b", name, cyc, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int sel, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (sel == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        int            sel;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs [5];

    // Single isolated transaction; checks grant/done timing, port-B drive and rdata
    task automatic run_vec(input vec_t v);
        set_req(v.sel, 1'b1, v.we, v.addr, v.wdata);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk1("vec_grant0", req0_grant, (v.sel == 0) && (k == 1));
            chk1("vec_grant1", req1_grant, (v.sel == 1) && (k == 1));
            chk1("vec_done0",  req0_done,  (v.sel == 0) && (k == v.lat));
            chk1("vec_done1",  req1_done,  (v.sel == 1) && (k == v.lat));
            chk1("vec_we_b",   we_b,       v.we && (k == 1));
            if (k == 1) begin
                chkw("vec_addr_b", DW'(addr_b), DW'(v.addr));
                if (v.we) chkw("vec_din_b", din_b, v.wdata);
                set_req(v.sel, 1'b0, v.we, v.addr, v.wdata);
            end
            if (k == v.lat) chkw("vec_rdata", rdata, v.rdata);
        end
    endtask

    // Reference model state for the random phase (transaction-level schedule)
    bit            exp_g  [2][NRAND+4];
    bit            exp_d  [2][NRAND+4];
    bit            exp_we [NRAND+4];
    bit            exp_rv_en [NRAND+4];
    logic [DW-1:0] exp_rv [NRAND+4];
    logic [AW-1:0] exp_a  [NRAND+4];
    logic [DW-1:0] exp_wd [NRAND+4];
    logic [DW-1:0] ref_mem [0:1023];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            ng, nd, g_id, g_cyc, free_at, w;
        logic          last;
        logic [DW-1:0] model_rdata;
        bit            pres [2];
        logic          t_we [2];
        logic [AW-1:0] t_a  [2];
        logic [DW-1:0] t_d  [2];

        vecs[0] = '{0, 1'b0, 18'h00100, '0,         3, DEAD};
        vecs[1] = '{1, 1'b1, 18'h30000, 128'h41,    2, DEAD};
        vecs[2] = '{1, 1'b0, 18'h30000, '0,         3, 128'h41};
        vecs[3] = '{0, 1'b1, 18'h00200, 128'hC0FFEE_0000_1234, 2, 128'h41};
        vecs[4] = '{0, 1'b0, 18'h00200, '0,         3, 128'hC0FFEE_0000_1234};

        rdy = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);

        // Reset state, then five idle cycles
        reset_dut();
        chk1("rst_grant0", req0_grant, 1'b0);
        chk1("rst_grant1", req1_grant, 1'b0);
        chk1("rst_done0",  req0_done,  1'b0);
        chk1("rst_done1",  req1_done,  1'b0);
        chk1("rst_we_b",   we_b,       1'b0);
        chkw("rst_addr_b", DW'(addr_b), '0);
        chkw("rst_din_b",  din_b,      '0);
        chkw("rst_rdata",  rdata,      '0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("idle_grant", req0_grant | req1_grant, 1'b0);
            chk1("idle_done",  req0_done | req1_done,   1'b0);
            chk1("idle_we_b",  we_b, 1'b0);
        end

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Both requesters continuously valid: grants alternate starting with req0
        reset_dut();
        set_req(0, 1'b1, 1'b0, 18'h00010, '0);
        set_req(1, 1'b1, 1'b0, 18'h00020, '0);
        ng = 0; nd = 0; g_id = 0; g_cyc = 0;
        for (int k = 0; k < 40 && nd < 8; k++) begin
            step();
            chk1("alt_grant_excl", req0_grant & req1_grant, 1'b0);
            chk1("alt_done_excl",  req0_done & req1_done,   1'b0);
            if (req0_grant | req1_grant) begin
                chk1("alt_order", req1_grant, ng[0]);
                g_id = int'(req1_grant); g_cyc = k; ng++;
                if (ng == 8) begin
                    req0_valid = 1'b0; req1_valid = 1'b0;
                end
            end
            if (req0_done | req1_done) begin
                chk1("alt_done_id", req1_done, g_id[0]);
                chkw("alt_latency", DW'(k - g_cyc), DW'(2));
                nd++;
            end
        end
        chk1("alt_all_done", nd == 8, 1'b1);

        // rdy low for 3 cycles during ISSUE of a req0 write
        step();
        set_req(0, 1'b1, 1'b1, 18'h00300, 128'h5A5A);
        step();
        chk1("stall_grant0", req0_grant, 1'b1);
        chk1("stall_we_pre", we_b, 1'b1);
        rdy = 1'b0;
        req0_valid = 1'b0;
        #1;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) step();
            chk1("stall_we_b",  we_b, 1'b0);
            chk1("stall_grant_held", req0_grant, 1'b1);
            chk1("stall_done0", req0_done, 1'b0);
            chkw("stall_addr_b", DW'(addr_b), DW'(18'h00300));
            chkw("stall_din_b", din_b, 128'h5A5A);
        end
        step();
        chk1("stall_we_b3", we_b, 1'b0);
        rdy = 1'b1;
        #1;
        chk1("stall_we_resume", we_b, 1'b1);
        step();
        chk1("stall_done0_late", req0_done, 1'b1);
        chk1("stall_we_off", we_b, 1'b0);
        chk1("stall_grant_off", req0_grant, 1'b0);
        step();
        chk1("stall_done0_off", req0_done, 1'b0);

        // Reset while a req1 read sits in CAPTURE
        set_req(1, 1'b1, 1'b0, 18'h30040, '0);
        step();
        chk1("rstc_grant1", req1_grant, 1'b1);
        req1_valid = 1'b0;
        step();
        chk1("rstc_done1_pre", req1_done, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk1("rstc_done1", req1_done, 1'b0);
        chkw("rstc_rdata", rdata, '0);
        chk1("rstc_we_b", we_b, 1'b0);
        step();
        chk1("rstc_done1_after", req1_done, 1'b0);
        set_req(0, 1'b1, 1'b1, 18'h00050, 128'h50);
        set_req(1, 1'b1, 1'b1, 18'h00060, 128'h60);
        step();
        chk1("rstc_first_g0", req0_grant, 1'b1);
        chk1("rstc_first_g1", req1_grant, 1'b0);
        req0_valid = 1'b0;
        step();
        chk1("rstc_done0", req0_done, 1'b1);
        step();
        chk1("rstc_second_g1", req1_grant, 1'b1);
        req1_valid = 1'b0;
        step();
        chk1("rstc_done1_w", req1_done, 1'b1);
        step();

        // Random traffic against a transaction-level schedule model
        reset_dut();
        for (int i = 0; i < 1024; i++) ref_mem[i] = ram[i];
        for (int i = 0; i < NRAND + 4; i++) begin
            exp_g[0][i] = 1'b0; exp_g[1][i] = 1'b0;
            exp_d[0][i] = 1'b0; exp_d[1][i] = 1'b0;
            exp_we[i] = 1'b0; exp_rv_en[i] = 1'b0;
            exp_rv[i] = '0; exp_a[i] = '0; exp_wd[i] = '0;
        end
        free_at = 0; last = 1'b1; model_rdata = '0;
        pres[0] = 1'b0; pres[1] = 1'b0;
        for (int r = 0; r < 2; r++) begin
            t_we[r] = 1'b0; t_a[r] = '0; t_d[r] = '0;
        end
        for (int rc = 0; rc < int'(NRAND); rc++) begin
            if (rc > 0) step();
            chk1("rnd_grant0", req0_grant, exp_g[0][rc]);
            chk1("rnd_grant1", req1_grant, exp_g[1][rc]);
            chk1("rnd_done0",  req0_done,  exp_d[0][rc]);
            chk1("rnd_done1",  req1_done,  exp_d[1][rc]);
            chk1("rnd_we_b",   we_b,       exp_we[rc]);
            if (exp_rv_en[rc]) model_rdata = exp_rv[rc];
            chkw("rnd_rdata", rdata, model_rdata);
            if (exp_g[0][rc] | exp_g[1][rc]) begin
                chkw("rnd_addr_b", DW'(addr_b), DW'(exp_a[rc]));
                if (exp_we[rc]) chkw("rnd_din_b", din_b, exp_wd[rc]);
            end
            for (int r = 0; r < 2; r++) begin
                if (exp_g[r][rc]) pres[r] = 1'b0;
                if (!pres[r] && $urandom_range(0, 2) == 0) begin
                    pres[r] = 1'b1;
                    t_we[r] = 1'($urandom_range(0, 1));
                    t_a[r]  = AW'($urandom);
                    t_d[r]  = {$urandom, $urandom, $urandom, $urandom};
                end
                set_req(r, pres[r], t_we[r], t_a[r], t_d[r]);
            end
            if (rc >= free_at && (pres[0] || pres[1])) begin
                w = (pres[0] && pres[1]) ? int'(!last) : int'(pres[1]);
                exp_g[w][rc+1] = 1'b1;
                exp_a[rc+1]    = t_a[w];
                exp_wd[rc+1]   = t_d[w];
                if (t_we[w]) begin
                    exp_we[rc+1] = 1'b1;
                    ref_mem[int'(t_a[w][9:0])] = t_d[w];
                    exp_d[w][rc+2] = 1'b1;
                    free_at = rc + 2;
                end else begin
                    exp_rv_en[rc+3] = 1'b1;
                    exp_rv[rc+3]    = ref_mem[int'(t_a[w][9:0])];
                    exp_d[w][rc+3]  = 1'b1;
                    free_at = rc + 3;
                end
                last = w[0];
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
